// File: rtl/ihex_loader.sv
// ihex_loader: Intel HEX boot-load sequencer.
// Takes ASCII bytes from the UART RX FIFO, parses records, verifies the checksum,
// then drains type-00 payloads to program memory one byte per write.
// Type 04 sets the upper 16 address bits, type 05 reports the entry point and
// type 01 signals completion.
// Optional build macro IHEX_LOADER_ECHO_EN adds a one-character status echo
// per record ('.' accepted, '!' rejected, 'E' end-of-file record).
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | hunting for ':'; everything else is discarded
// COUNT   | receiving the byte-count field
// ADDR_H  | receiving the upper load-offset byte
// ADDR_L  | receiving the lower load-offset byte
// TYPE    | receiving the record type
// DATA    | receiving payload bytes into the record buffer
// CSUM    | receiving the checksum byte, then record is applied
// DRAIN   | writing buffered payload to memory, RX back-pressured
module ihex_loader #(
  parameter int MAX_REC_BYTES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [31:0] wr_addr_o,
  output logic [31:0] wr_data_o,
  output logic [3:0]  wr_strb_o,
  output logic        wr_valid_o,
  input  logic        wr_ready_i,
  output logic [31:0] entry_o,
  output logic        entry_valid_o,
  output logic        done_o,
  output logic        err_o,
  output logic [2:0]  err_code_o
`ifdef IHEX_LOADER_ECHO_EN
  ,
  output logic [7:0]  echo_data_o,
  output logic        echo_valid_o,
  input  logic        echo_ready_i
`endif
);

  localparam int         IW      = $clog2(MAX_REC_BYTES);
  localparam logic [7:0] MAX_CNT = 8'(MAX_REC_BYTES);
  localparam logic [7:0] COLON   = 8'h3A;

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_ADDR_H, S_ADDR_L, S_TYPE, S_DATA, S_CSUM, S_DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic        phase_q;
  logic [3:0]  hi_nib_q;
  logic [7:0]  count_q;
  logic [15:0] addr_q;
  logic [7:0]  type_q;
  logic [7:0]  sum_q;
  logic [7:0]  idx_q;
  logic [15:0] ext_base_q;
  logic [31:0] entry_q;
  logic        entry_valid_q;
  logic        done_q;
  logic        err_q;
  logic [2:0]  err_code_q;
  logic [7:0]  buf_q [MAX_REC_BYTES];

  logic        rx_fire;
  logic        wr_fire;
  logic        in_rec;
  logic        hex_ok;
  logic [3:0]  nib;
  logic [7:0]  byte_val;
  logic [7:0]  csum_total;
  logic        byte_done;
  logic        err_set;
  logic [2:0]  err_val;
  logic        done_set;
  logic        ext_set;
  logic        entry_set;
  logic [31:0] drain_addr;

  assign rx_ready_o = (state_q != S_DRAIN);
  assign wr_valid_o = (state_q == S_DRAIN);
  assign rx_fire    = rx_valid_i && rx_ready_o;
  assign wr_fire    = wr_valid_o && wr_ready_i;
  assign in_rec     = (state_q != S_IDLE) && (state_q != S_DRAIN);
  assign byte_val   = {hi_nib_q, nib};
  assign csum_total = sum_q + byte_val;

  // 32-bit address wraps naturally; offset+index carries into the upper half
  assign drain_addr = {ext_base_q, 16'h0000} + {16'h0000, addr_q} + {24'h000000, idx_q};
  assign wr_addr_o  = wr_valid_o ? drain_addr : 32'h0;
  assign wr_data_o  = wr_valid_o ? {4{buf_q[idx_q[IW-1:0]]}} : 32'h0;
  assign wr_strb_o  = wr_valid_o ? (4'b0001 << drain_addr[1:0]) : 4'b0000;

  assign entry_o       = entry_q;
  assign entry_valid_o = entry_valid_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign err_code_o    = err_code_q;

  // ASCII hex digit decode
  always_comb begin
    hex_ok = 1'b1;
    nib    = 4'h0;
    if (rx_data_i >= 8'h30 && rx_data_i <= 8'h39)
      nib = rx_data_i[3:0];
    else if ((rx_data_i >= 8'h41 && rx_data_i <= 8'h46) ||
             (rx_data_i >= 8'h61 && rx_data_i <= 8'h66))
      nib = rx_data_i[3:0] + 4'd9;
    else
      hex_ok = 1'b0;
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and record-level decisions
  always_comb begin
    state_d   = state_q;
    byte_done = 1'b0;
    err_set   = 1'b0;
    err_val   = 3'd0;
    done_set  = 1'b0;
    ext_set   = 1'b0;
    entry_set = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (rx_fire && rx_data_i == COLON) state_d = S_COUNT;
      end
      S_DRAIN: begin
        if (wr_fire && idx_q == count_q - 8'd1) state_d = S_IDLE;
      end
      default: begin
        if (rx_fire) begin
          if (!hex_ok) begin
            err_set = 1'b1;
            err_val = 3'd1;
            state_d = (rx_data_i == COLON) ? S_COUNT : S_IDLE;
          end else if (phase_q) begin
            byte_done = 1'b1;
            case (state_q)
              S_COUNT: begin
                if (byte_val > MAX_CNT) begin
                  err_set = 1'b1;
                  err_val = 3'd3;
                  state_d = S_IDLE;
                end else begin
                  state_d = S_ADDR_H;
                end
              end
              S_ADDR_H: state_d = S_ADDR_L;
              S_ADDR_L: state_d = S_TYPE;
              S_TYPE:   state_d = (count_q == 8'd0) ? S_CSUM : S_DATA;
              S_DATA:   if (idx_q == count_q - 8'd1) state_d = S_CSUM;
              S_CSUM: begin
                state_d = S_IDLE;
                if (csum_total != 8'h00) begin
                  err_set = 1'b1;
                  err_val = 3'd2;
                end else begin
                  case (type_q)
                    8'h00: if (count_q != 8'd0) state_d = S_DRAIN;
                    8'h01: done_set = 1'b1;
                    8'h04: begin
                      if (count_q == 8'd2) ext_set = 1'b1;
                      else begin err_set = 1'b1; err_val = 3'd3; end
                    end
                    8'h05: begin
                      if (count_q == 8'd4) entry_set = 1'b1;
                      else begin err_set = 1'b1; err_val = 3'd3; end
                    end
                    default: begin err_set = 1'b1; err_val = 3'd4; end
                  endcase
                end
              end
              default: ;
            endcase
          end
        end
      end
    endcase
  end

  // Field capture, running checksum, buffer index and sticky status
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      phase_q       <= 1'b0;
      hi_nib_q      <= 4'h0;
      count_q       <= 8'h00;
      addr_q        <= 16'h0000;
      type_q        <= 8'h00;
      sum_q         <= 8'h00;
      idx_q         <= 8'h00;
      ext_base_q    <= 16'h0000;
      entry_q       <= 32'h0;
      entry_valid_q <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      err_code_q    <= 3'd0;
    end else begin
      if (rx_fire) begin
        if (in_rec && hex_ok) phase_q <= ~phase_q;
        else                  phase_q <= 1'b0;
        if (in_rec && hex_ok && !phase_q) hi_nib_q <= nib;
      end
      if (byte_done) begin
        sum_q <= (state_q == S_COUNT) ? byte_val : csum_total;
        case (state_q)
          S_COUNT:  count_q       <= byte_val;
          S_ADDR_H: addr_q[15:8]  <= byte_val;
          S_ADDR_L: addr_q[7:0]   <= byte_val;
          S_TYPE:   type_q        <= byte_val;
          default: ;
        endcase
      end
      if (byte_done && state_q == S_TYPE)         idx_q <= 8'h00;
      else if (byte_done && state_q == S_DATA)    idx_q <= idx_q + 8'd1;
      else if (state_q == S_CSUM && state_d == S_DRAIN) idx_q <= 8'h00;
      else if (wr_fire)                           idx_q <= idx_q + 8'd1;
      if (ext_set) ext_base_q <= {buf_q[0], buf_q[1]};
      if (entry_set) begin
        entry_q       <= {buf_q[0], buf_q[1], buf_q[2], buf_q[3]};
        entry_valid_q <= 1'b1;
      end
      if (done_set) done_q <= 1'b1;
      if (err_set) begin
        err_q      <= 1'b1;
        err_code_q <= err_val;
      end
    end
  end

  // Record payload buffer; contents are only meaningful below count_q
  always_ff @(posedge clk_i) begin
    if (byte_done && state_q == S_DATA) buf_q[idx_q[IW-1:0]] <= byte_val;
  end

`ifdef IHEX_LOADER_ECHO_EN
  logic       rec_end;
  logic [7:0] echo_char;
  logic [7:0] echo_data_q;
  logic       echo_valid_q;

  assign rec_end   = err_set || (byte_done && state_q == S_CSUM);
  assign echo_char = err_set ? 8'h21 : ((type_q == 8'h01) ? 8'h45 : 8'h2E);

  // Single-entry echo register; newest status overwrites an unread one
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      echo_data_q  <= 8'h00;
      echo_valid_q <= 1'b0;
    end else if (rec_end) begin
      echo_data_q  <= echo_char;
      echo_valid_q <= 1'b1;
    end else if (echo_ready_i) begin
      echo_valid_q <= 1'b0;
    end
  end

  assign echo_data_o  = echo_data_q;
  assign echo_valid_o = echo_valid_q;
`endif

endmodule

// File: tb/tb_ihex_loader.sv
// tb_ihex_loader: directed and randomized Intel HEX records against a
// record-level reference model (expected writes kept in queues).
module tb_ihex_loader;
  localparam int MAX_REC = 16;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [7:0]  rx_data_i = 8'h00;
  logic        rx_valid_i = 1'b0;
  logic        rx_ready_o;
  logic [31:0] wr_addr_o;
  logic [31:0] wr_data_o;
  logic [3:0]  wr_strb_o;
  logic        wr_valid_o;
  logic        wr_ready_i = 1'b0;
  logic [31:0] entry_o;
  logic        entry_valid_o;
  logic        done_o;
  logic        err_o;
  logic [2:0]  err_code_o;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int rdy_mode = 0;

  // reference model state
  logic [15:0] m_ext;
  logic [31:0] m_entry;
  logic        m_entry_v, m_done, m_err;
  logic [2:0]  m_code;
  logic [31:0] exp_addr_q[$];
  logic [7:0]  exp_byte_q[$];

  // monitor bookkeeping
  int          rec_wr_n = 0;
  int          last_wr_cyc = 0;
  int          csum_cyc = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr, prev_data;
  logic [3:0]  prev_strb;
  logic [31:0] first_addr, first_data, last_addr;
  logic [3:0]  first_strb, last_strb;
  logic [31:0] mon_a;
  logic [7:0]  mon_b;

  logic [7:0]  body[$];

  ihex_loader #(.MAX_REC_BYTES(MAX_REC)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .wr_strb_o(wr_strb_o),
    .wr_valid_o(wr_valid_o), .wr_ready_i(wr_ready_i),
    .entry_o(entry_o), .entry_valid_o(entry_valid_o), .done_o(done_o),
    .err_o(err_o), .err_code_o(err_code_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n, input bit lc);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return (lc ? 8'h61 : 8'h41) + {4'h0, n} - 8'd10;
  endfunction

  task automatic model_reset();
    m_ext = 16'h0; m_entry = 32'h0; m_entry_v = 1'b0; m_done = 1'b0;
    m_err = 1'b0; m_code = 3'd0;
    exp_addr_q.delete(); exp_byte_q.delete();
  endtask

  // applies one complete record (count..csum) by the Intel HEX rules
  task automatic model_record(input logic [7:0] rec[$]);
    int cnt;
    logic [7:0] s;
    logic [31:0] a;
    cnt = int'(rec[0]);
    s = 8'h00;
    if (cnt > MAX_REC) begin m_err = 1'b1; m_code = 3'd3; return; end
    foreach (rec[i]) s = s + rec[i];
    if (s != 8'h00) begin m_err = 1'b1; m_code = 3'd2; return; end
    case (rec[3])
      8'h00: for (int i = 0; i < cnt; i++) begin
        a = 32'(m_ext) * 32'h10000 + 32'(rec[1]) * 32'h100 + 32'(rec[2]) + 32'(i);
        exp_addr_q.push_back(a);
        exp_byte_q.push_back(rec[4+i]);
      end
      8'h01: m_done = 1'b1;
      8'h04: if (cnt == 2) m_ext = {rec[4], rec[5]};
             else begin m_err = 1'b1; m_code = 3'd3; end
      8'h05: if (cnt == 4) begin m_entry = {rec[4], rec[5], rec[6], rec[7]}; m_entry_v = 1'b1; end
             else begin m_err = 1'b1; m_code = 3'd3; end
      default: begin m_err = 1'b1; m_code = 3'd4; end
    endcase
  endtask

  task automatic send_char(input logic [7:0] c);
    bit acc;
    int n;
    acc = 1'b0; n = 0;
    rx_data_i = c; rx_valid_i = 1'b1;
    while (!acc && n < 500) begin
      @(negedge clk_i); acc = rx_ready_o;
      @(posedge clk_i); #1; n++;
    end
    if (!acc) check_val("rx_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
    rx_valid_i = 1'b0;
  endtask

  task automatic send_rec(input logic [7:0] bdy[$], input bit bad_csum, input bit eol);
    logic [7:0] rec[$];
    logic [7:0] s;
    bit lc;
    lc = 1'($urandom_range(0, 1));
    s = 8'h00;
    rec = bdy;
    foreach (bdy[i]) s = s + bdy[i];
    rec.push_back((8'h00 - s) ^ (bad_csum ? 8'h01 : 8'h00));
    model_record(rec);
    rec_wr_n = 0;
    send_char(8'h3A);
    foreach (rec[i]) begin
      send_char(hexc(rec[i][7:4], lc));
      send_char(hexc(rec[i][3:0], lc));
    end
    csum_cyc = cyc;
    rx_valid_i = 1'b0;
    if (eol) begin send_char(8'h0D); send_char(8'h0A); rx_valid_i = 1'b0; end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(negedge clk_i);
      ok = rx_ready_o && (exp_addr_q.size() == 0);
    end
    check_val("drain_done", 32'(ok), 32'd1);
    @(posedge clk_i); #1;
  endtask

  task automatic check_model();
    check_val("entry_valid", 32'(entry_valid_o), 32'(m_entry_v));
    check_val("entry", entry_o, m_entry);
    check_val("done", 32'(done_o), 32'(m_done));
    check_val("err", 32'(err_o), 32'(m_err));
    check_val("err_code", 32'(err_code_o), 32'(m_code));
  endtask

  task automatic check_reset_outputs();
    check_val("rst_rx_ready", 32'(rx_ready_o), 32'd1);
    check_val("rst_wr_valid", 32'(wr_valid_o), 32'd0);
    check_val("rst_wr_addr", wr_addr_o, 32'd0);
    check_val("rst_wr_data", wr_data_o, 32'd0);
    check_val("rst_wr_strb", 32'(wr_strb_o), 32'd0);
    check_val("rst_entry", entry_o, 32'd0);
    check_val("rst_entry_valid", 32'(entry_valid_o), 32'd0);
    check_val("rst_done", 32'(done_o), 32'd0);
    check_val("rst_err", 32'(err_o), 32'd0);
    check_val("rst_err_code", 32'(err_code_o), 32'd0);
  endtask

  // memory-side ready pattern: 0 always, 1 toggle, 2 random, 3 stalled
  initial forever begin
    @(posedge clk_i); #1;
    case (rdy_mode)
      0:       wr_ready_i = 1'b1;
      1:       wr_ready_i = ~wr_ready_i;
      2:       wr_ready_i = 1'($urandom_range(0, 1));
      default: wr_ready_i = 1'b0;
    endcase
  end

  // write-port monitor against the expected-write queue
  always @(negedge clk_i) begin
    if (!rst_i) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_val("hold_valid", 32'(wr_valid_o), 32'd1);
        check_val("hold_addr", wr_addr_o, prev_addr);
        check_val("hold_data", wr_data_o, prev_data);
        check_val("hold_strb", 32'(wr_strb_o), 32'(prev_strb));
      end
      if (wr_valid_o) check_val("rx_ready_drain", 32'(rx_ready_o), 32'd0);
      if (wr_valid_o && wr_ready_i) begin
        if (exp_addr_q.size() == 0) begin
          check_val("wr_unexpected", 32'd1, 32'd0);
        end else begin
          mon_a = exp_addr_q.pop_front();
          mon_b = exp_byte_q.pop_front();
          check_val("wr_addr", wr_addr_o, mon_a);
          check_val("wr_data", wr_data_o, 32'(mon_b) * 32'h01010101);
          check_val("wr_strb", 32'(wr_strb_o), 32'd1 << (mon_a % 32'd4));
          if (rdy_mode == 0) begin
            if (rec_wr_n == 0) check_val("first_wr_lat", 32'(cyc), 32'(csum_cyc));
            else               check_val("wr_back2back", 32'(cyc), 32'(last_wr_cyc + 1));
          end
          if (rec_wr_n == 0) begin
            first_addr = wr_addr_o; first_data = wr_data_o; first_strb = wr_strb_o;
          end
          last_addr = wr_addr_o; last_strb = wr_strb_o;
          rec_wr_n++;
          last_wr_cyc = cyc;
        end
      end
      prev_stall = wr_valid_o && !wr_ready_i;
      prev_addr = wr_addr_o; prev_data = wr_data_o; prev_strb = wr_strb_o;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, cnt, t;
    logic [15:0] ad;
    bit ok;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    check_reset_outputs();
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rdy_mode = 0;

    // extended linear address 0x8010
    body = {8'h02, 8'h00, 8'h00, 8'h04, 8'h80, 8'h10};
    send_rec(body, 1'b0, 1'b1);
    wait_idle();
    check_model();
    check_val("ext_rec_no_err", 32'(err_o), 32'd0);

    // 16-byte data record with ready held high
    body = {8'h10, 8'h00, 8'h00, 8'h00,
            8'h13, 8'h01, 8'h01, 8'hFF, 8'h23, 8'h24, 8'h11, 8'h00,
            8'h17, 8'h02, 8'h00, 8'h00, 8'h13, 8'h02, 8'h82, 8'h18};
    send_rec(body, 1'b0, 1'b1);
    wait_idle();
    check_model();
    check_val("data16_count", 32'(rec_wr_n), 32'd16);
    check_val("data16_first_addr", first_addr, 32'h80100000);
    check_val("data16_first_data", first_data, 32'h13131313);
    check_val("data16_first_strb", 32'(first_strb), 32'h1);
    check_val("data16_last_addr", last_addr, 32'h8010000F);
    check_val("data16_last_strb", 32'(last_strb), 32'h8);

    // same record with toggling ready
    rdy_mode = 1;
    send_rec(body, 1'b0, 1'b1);
    wait_idle();
    check_val("toggle_count", 32'(rec_wr_n), 32'd16);
    check_val("toggle_last_addr", last_addr, 32'h8010000F);
    rdy_mode = 0;

    // entry point, then end-of-file
    body = {8'h04, 8'h00, 8'h00, 8'h05, 8'h80, 8'h10, 8'h00, 8'h00};
    send_rec(body, 1'b0, 1'b1);
    wait_idle();
    check_val("entry_value", entry_o, 32'h80100000);
    check_val("done_before_eof", 32'(done_o), 32'd0);
    body = {8'h00, 8'h00, 8'h00, 8'h01};
    send_rec(body, 1'b0, 1'b0);
    check_val("done_next_cycle", 32'(done_o), 32'd1);
    send_str("\n");
    wait_idle();
    check_model();

    // bad checksum on an extended address record (":0200000480106B")
    body = {8'h02, 8'h00, 8'h00, 8'h04, 8'h12, 8'h34};
    body[4] = 8'h80; body[5] = 8'h10;
    send_rec(body, 1'b1, 1'b1);
    wait_idle();
    check_model();
    check_val("bad_csum_code", 32'(err_code_o), 32'd2);
    body = {8'h01, 8'h00, 8'h40, 8'h00, 8'hA5};
    send_rec(body, 1'b0, 1'b1);
    wait_idle();
    check_val("ext_unchanged_addr", first_addr, 32'h80100040);

    // non-hex character inside a record
    send_str(":0G\n");
    m_err = 1'b1; m_code = 3'd1;
    wait_idle();
    check_model();

    // oversize count is rejected as soon as COUNT completes
    send_str(":11");
    check_val("count_err_immediate", 32'(err_code_o), 32'd3);
    send_str("0000000000\n");
    m_code = 3'd3;
    wait_idle();
    check_model();

    // offset + index carrying into the upper half
    body = {8'h02, 8'h00, 8'h00, 8'h04, 8'h12, 8'h34};
    send_rec(body, 1'b0, 1'b1);
    wait_idle();
    body = {8'h10, 8'hFF, 8'hF8, 8'h00};
    for (int i = 0; i < 16; i++) body.push_back(8'($urandom));
    send_rec(body, 1'b0, 1'b1);
    wait_idle();
    check_val("carry_last_addr", last_addr, 32'h12350007);
    check_model();

    // randomized records
    for (int r = 0; r < 30; r++) begin
      kind = $urandom_range(0, 9);
      rdy_mode = $urandom_range(0, 2);
      ad = ($urandom_range(0, 3) == 0) ? (16'hFFF0 + 16'($urandom_range(0, 15))) : 16'($urandom);
      body = {};
      if (kind <= 5) begin
        cnt = $urandom_range(0, 16); t = 0;
      end else if (kind == 6) begin
        cnt = ($urandom_range(0, 3) == 0) ? 3 : 2; t = 4;
      end else if (kind == 7) begin
        cnt = 4; t = 5;
      end else if (kind == 8) begin
        cnt = $urandom_range(0, 4); t = $urandom_range(2, 255);
        if (t == 4 || t == 5) t = 3;
      end else begin
        cnt = $urandom_range(17, 20); t = 0;
      end
      body.push_back(8'(cnt));
      body.push_back(ad[15:8]);
      body.push_back(ad[7:0]);
      body.push_back(8'(t));
      for (int i = 0; i < cnt; i++) body.push_back(8'($urandom));
      send_rec(body, ($urandom_range(0, 7) == 0), 1'b1);
      wait_idle();
      check_model();
    end

    // reset in the middle of a drain
    rdy_mode = 3;
    body = {8'h10, 8'h20, 8'h00, 8'h00};
    for (int i = 0; i < 16; i++) body.push_back(8'($urandom));
    send_rec(body, 1'b0, 1'b0);
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk_i);
      ok = wr_valid_o;
    end
    check_val("drain_reached", 32'(ok), 32'd1);
    #2;
    rst_i = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    rec_wr_n = 0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    rdy_mode = 0;
    @(posedge clk_i); #1;
    body = {8'h04, 8'h01, 8'h00, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_rec(body, 1'b0, 1'b1);
    wait_idle();
    check_model();
    check_val("post_reset_first_addr", first_addr, 32'h00000100);
    check_val("post_reset_count", 32'(rec_wr_n), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
